// File: rtl/console_pkg.sv
// Shared definitions for the text console renderer: CGA palette,
// attribute byte layout and a constant-expression ceil(log2) helper.
package console_pkg;

    // Attribute byte: [3:0] foreground, [6:4] background, [7] blink.
    localparam int unsigned ATTR_FG_LSB = 0;
    localparam int unsigned ATTR_FG_MSB = 3;
    localparam int unsigned ATTR_BG_LSB = 4;
    localparam int unsigned ATTR_BG_MSB = 6;
    localparam int unsigned ATTR_BLINK  = 7;

    // Standard 16-colour CGA palette, index 15 first.
    localparam logic [15:0][23:0] PALETTE = {
        24'hFFFFFF, 24'hFFFF55, 24'hFF55FF, 24'hFF5555,
        24'h55FFFF, 24'h55FF55, 24'h5555FF, 24'h555555,
        24'hAAAAAA, 24'hAA5500, 24'hAA00AA, 24'hAA0000,
        24'h00AAAA, 24'h00AA00, 24'h0000AA, 24'h000000
    };

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/console_delay.sv
// Fixed-depth shift register carrying pixel side-band data alongside
// the text RAM read.
module console_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk_pixel,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one stage per cycle; reset clears all in-flight entries.
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/console_renderer.sv
// Text-mode renderer: maps cx/cy to a character cell, fetches the cell
// from text RAM and the glyph row from font ROM, then emits RGB with a
// fixed RAM_LATENCY+3 cycle latency.
module console_renderer
    import console_pkg::*;
#(
    parameter int unsigned BIT_WIDTH   = 10,
    parameter int unsigned BIT_HEIGHT  = 10,
    parameter int unsigned GLYPH_W     = 8,
    parameter int unsigned GLYPH_H     = 16,
    parameter int unsigned COLS        = 80,
    parameter int unsigned ROWS        = 30,
    parameter int unsigned RAM_LATENCY = 1,
    parameter int unsigned BLINK_LOG2  = 5
) (
    input  logic                            clk_pixel,
    input  logic                            reset_n,
    input  logic [BIT_WIDTH-1:0]            cx,
    input  logic [BIT_HEIGHT-1:0]           cy,
    input  logic                            active,
    input  logic                            cursor_en,
    input  logic [clog2(COLS)-1:0]          cursor_col,
    input  logic [clog2(ROWS)-1:0]          cursor_row,
    output logic [clog2(COLS*ROWS)-1:0]     text_addr,
    input  logic [15:0]                     text_data,
    output logic [7+clog2(GLYPH_H):0]       font_addr,
    input  logic [GLYPH_W-1:0]              font_row,
    output logic [23:0]                     rgb,
    output logic                            rgb_valid
);

    localparam int unsigned GXB    = clog2(GLYPH_W);
    localparam int unsigned GYB    = clog2(GLYPH_H);
    localparam int unsigned ADDR_W = clog2(COLS*ROWS);

    // Blink phase travels with the pixel so a frame-start increment only
    // affects pixels sampled after it, regardless of pipeline depth.
    typedef struct packed {
        logic           valid;
        logic           in_grid;
        logic           cursor_hit;
        logic           blink_phase;
        logic [GYB-1:0] glyph_y;
        logic [GXB-1:0] glyph_x;
    } side_t;

    localparam int unsigned SIDE_W = $bits(side_t);

    logic [BIT_WIDTH-GXB-1:0]  col;
    logic [BIT_HEIGHT-GYB-1:0] row;
    logic                      in_grid;
    logic                      cursor_hit;
    logic                      frame_start;
    logic [BLINK_LOG2:0]       blink_cnt;
    side_t                     s0_side, dl_side, s1_side, s2_side;
    logic [SIDE_W-1:0]         dl_q;
    logic [7:0]                s1_attr, s2_attr;
    logic                      pixel_on;
    logic [23:0]               fg, bg, pix_rgb;

    assign col         = cx[BIT_WIDTH-1:GXB];
    assign row         = cy[BIT_HEIGHT-1:GYB];
    assign in_grid     = active && (32'(col) < COLS) && (32'(row) < ROWS);
    // Requiring in_grid makes an out-of-range cursor column never match.
    assign cursor_hit  = cursor_en && in_grid &&
                         (32'(col) == 32'(cursor_col)) &&
                         (32'(row) == 32'(cursor_row));
    assign frame_start = (cx == '0) && (cy == '0);

    // Frame counter; MSB is the blink phase.
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            blink_cnt <= '0;
        end else if (frame_start) begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // S0: cell lookup and side-band capture; address holds outside the grid.
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            s0_side   <= '0;
            text_addr <= '0;
        end else begin
            s0_side.valid       <= active;
            s0_side.in_grid     <= in_grid;
            s0_side.cursor_hit  <= cursor_hit;
            s0_side.blink_phase <= blink_cnt[BLINK_LOG2];
            s0_side.glyph_y     <= cy[GYB-1:0];
            s0_side.glyph_x     <= cx[GXB-1:0];
            if (in_grid) begin
                text_addr <= ADDR_W'(32'(row) * COLS + 32'(col));
            end
        end
    end

    console_delay #(
        .WIDTH (SIDE_W),
        .DEPTH (RAM_LATENCY)
    ) u_delay (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .d         (s0_side),
        .q         (dl_q)
    );

    assign dl_side = side_t'(dl_q);

    // S1: font lookup from fetched character; S1b realigns with font ROM latency.
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            font_addr <= '0;
            s1_attr   <= '0;
            s1_side   <= '0;
            s2_attr   <= '0;
            s2_side   <= '0;
        end else begin
            font_addr <= {text_data[7:0], dl_side.glyph_y};
            s1_attr   <= text_data[15:8];
            s1_side   <= dl_side;
            s2_attr   <= s1_attr;
            s2_side   <= s1_side;
        end
    end

    assign pixel_on = font_row[GXB'(GLYPH_W - 1) - s2_side.glyph_x];
    assign fg       = PALETTE[s2_attr[ATTR_FG_MSB:ATTR_FG_LSB]];
    assign bg       = PALETTE[{1'b0, s2_attr[ATTR_BG_MSB:ATTR_BG_LSB]}];

    // S2 colour: cursor underline in phase 0, text blink suppressed in cursor cell.
    always_comb begin
        pix_rgb = pixel_on ? fg : bg;
        if (s2_side.cursor_hit && !s2_side.blink_phase &&
            (32'(s2_side.glyph_y) >= GLYPH_H - 2)) begin
            pix_rgb = fg;
        end else if (s2_attr[ATTR_BLINK] && s2_side.blink_phase && !s2_side.cursor_hit) begin
            pix_rgb = bg;
        end
    end

    // Output register: black outside the grid, invalid when not active.
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            rgb       <= '0;
            rgb_valid <= 1'b0;
        end else begin
            rgb_valid <= s2_side.valid;
            rgb       <= (s2_side.valid && s2_side.in_grid) ? pix_rgb : '0;
        end
    end

endmodule

// File: doc/console_renderer.md
Name: console_renderer

Overview:
- Parametrised text-mode renderer. Converts pixel coordinates into RGB pixels using a COLS x ROWS character grid held in an external text RAM and an external font ROM.
- Sits between the video timing generator (cx/cy) and the HDMI video input, in the clk_pixel domain.
- Generalises the fixed 8x16 console with:
  - configurable glyph and grid geometry;
  - an explicit fetch pipeline with configurable RAM latency;
  - out-of-grid blanking;
  - a hardware cursor;
  - a frame-counted blink phase.

Parameters:
- BIT_WIDTH, 10, width of cx.
- BIT_HEIGHT, 10, width of cy.
- GLYPH_W, 8, glyph width in pixels; power of two, 4..16.
- GLYPH_H, 16, glyph height in pixels; power of two, 8..32.
- COLS, 80, text columns.
- ROWS, 30, text rows.
- RAM_LATENCY, 1, text RAM read latency in cycles, 1..3.
- BLINK_LOG2, 5, frames per blink half-period = 2^BLINK_LOG2.

Ports:
- clk_pixel, input, 1, pixel clock.
- reset_n, input, 1, synchronous active-low reset.
- cx, input, BIT_WIDTH, current pixel x.
- cy, input, BIT_HEIGHT, current pixel y.
- active, input, 1, cx/cy lies in the visible area.
- cursor_en, input, 1, cursor enable.
- cursor_col, input, clog2(COLS), cursor column.
- cursor_row, input, clog2(ROWS), cursor row.
- text_addr, output, clog2(COLS*ROWS), text RAM address; value = row*COLS + col.
- text_data, input, 16, {attribute[7:0], character[7:0]}; valid RAM_LATENCY cycles after text_addr.
- font_addr, output, 8+clog2(GLYPH_H), {character, glyph_y}.
- font_row, input, GLYPH_W, glyph row bits; valid 1 cycle after font_addr; MSB = leftmost pixel.
- rgb, output, 24, pixel colour.
- rgb_valid, output, 1, rgb corresponds to a pixel presented with active=1.

Behaviour:
- Reset (reset_n=0 at a clk_pixel edge):
  - rgb=0, rgb_valid=0, text_addr=0, font_addr=0.
  - All pipeline valid flags cleared; blink counter cleared.
  - Reset mid-frame discards in-flight pixels; no pixel emerges from before reset.
- Stage S0 (registered on cx/cy):
  - col = cx >> log2(GLYPH_W); row = cy >> log2(GLYPH_H).
  - glyph_x = low bits of cx; glyph_y = low bits of cy.
  - in_grid = active && col<COLS && row<ROWS.
  - text_addr is driven only when in_grid; otherwise it holds its previous value.
  - The multiply by COLS is constant; a shift-add implementation is acceptable.
- Delay line: glyph_x, glyph_y, in_grid, valid (=active) and the cursor-hit flag are carried through a RAM_LATENCY-deep delay line alongside the RAM read.
- Stage S1: font_addr = {text_data[7:0], glyph_y}. Attribute and delayed side-band are registered.
- Stage S2:
  - pixel_on = font_row[GLYPH_W-1-glyph_x].
  - fg = PALETTE[attr[3:0]]; bg = PALETTE[{1'b0,attr[6:4]}].
  - Text blink: attr[7] with blink_phase=1 renders the cell as all-bg.
  - Cursor: a cell with cursor_hit (cursor_en && col==cursor_col && row==cursor_row, sampled in S0) draws glyph rows GLYPH_H-2 and GLYPH_H-1 as fg while blink_phase=0. Cursor overrides text blink.
  - !in_grid with valid: rgb=0.
  - !valid: rgb=0, rgb_valid=0.
- Latency: rgb/rgb_valid appear exactly RAM_LATENCY+3 cycles after the cx/cy/active sample. The pipeline is fully streaming with one pixel per cycle and no stalls.
- Blink counter:
  - Width BLINK_LOG2+1; increments once per frame, when cx==0 && cy==0 is sampled.
  - blink_phase = MSB; wraps freely.
  - The frame-start increment and the S0 sample of the same pixel coexist: the increment affects pixels sampled after it.
- Cursor position changes take effect on the next S0 sample; no tearing protection.
- Out-of-range cursor (cursor_col>=COLS) never matches.

Decomposition:
- Package console_pkg:
  - 16-entry 24-bit CGA PALETTE constant.
  - attribute field positions: FG, BG, BLINK.
  - clog2 helper.
- Sub-module console_delay: parametrised-depth shift register of a side-band vector, instantiated for the RAM_LATENCY delay line.

Test Plan:
- Reset: hold reset_n=0 for 5 cycles with active=1 -> rgb=0 and rgb_valid=0 throughout, and for RAM_LATENCY+3 cycles after release.
- Latency and bit order:
  - Setup: cell (0,0) = char 0x41, attr 0x1F; font row 0 = 8'b1000_0001; RAM_LATENCY=2.
  - Stimulus: sweep cx=0..7, cy=0.
  - Expected: rgb=PALETTE[15] at cx 0 and 7, PALETTE[1] at cx 1..6, each 5 cycles after the sample.
- Grid bounds: with COLS=80, sample cx=640, cy=0, active=1 -> rgb=0, rgb_valid=1, text_addr unchanged. Sample active=0 -> rgb_valid=0.
- Address mapping: cx=8*5, cy=16*3 -> text_addr=245.
- Text blink:
  - Setup: attr 0x9F, all-ones font; BLINK_LOG2=1.
  - Stimulus: frames 0-1, then frames 2-3.
  - Expected: PALETTE[15] in frames 0-1; PALETTE[1] in frames 2-3.
- Cursor:
  - Setup: cursor_en=1 at (2,1); blank glyph (font_row=0); attr 0x07.
  - Expected: glyph rows 14-15 of that cell = PALETTE[7] in phase 0 and PALETTE[0] in phase 1; rows 0-13 = PALETTE[0].
